mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port external SRAM between the fetch port (PC-driven instruction read) and the
//  memory-stage data port (load/store with 2-bit read/write control). Data accesses have priority.
//  Asserts stall so the pipeline holds its stage registers. Shapes the SRAM strobes (ce_n/oe_n/we_n).
//  Placed between the CPU core and the board SRAM pins.
// PARAMETERS
//  ADDR_W        16  SRAM / CPU address width
//  DATA_W        16  SRAM / CPU data width
//  READ_CYCLES   1   cycles oe_n is held low for a data read (>=1)
//  WRITE_CYCLES  2   cycles we_n is held low for a data write (>=1)
// PORTS
//  clk         in   1       system clock, all state on rising edge
//  rst         in   1       asynchronous, active-high reset
//  if_addr     in   ADDR_W  fetch address (next PC)
//  if_rdata    out  DATA_W  fetched instruction word
//  if_valid    out  1       if_rdata updated this cycle (1-cycle pulse per fetch)
//  me_addr     in   ADDR_W  data address from memory stage
//  me_ctrl     in   2       [1]=read, [0]=write; 2'b00 = no access
//  me_wdata    in   DATA_W  store data
//  me_rdata    out  DATA_W  load result, held until next read completes
//  me_done     out  1       1-cycle pulse: data access complete
//  stall       out  1       hold pipeline; comb: (me_ctrl!=0) && !me_done && !rst
//  ram_addr    out  ADDR_W  SRAM address (registered)
//  ram_wdata   out  DATA_W  SRAM write data (registered)
//  ram_rdata   in   DATA_W  SRAM read data
//  ram_ce_n / ram_oe_n / ram_we_n  out  1 each  SRAM strobes, active-low, registered
// BEHAVIOUR
//  Reset: state IDLE; ram_ce_n=ram_oe_n=ram_we_n=1; ram_addr=ram_wdata=0; if_rdata=0; if_valid=0;
//   me_rdata=0; me_done=0; stall=0. Reset mid-write raises we_n at once; that word is undefined.
//  States: IDLE, FETCH, DREAD, DW_SETUP, DW_PULSE, DW_HOLD, DONE.
//  Launch decision (from IDLE, FETCH or DONE): if me_ctrl!=0 and state!=DONE, start a data op;
//   otherwise enter FETCH with ram_addr<=if_addr, ce_n=0, oe_n=0.
//  DONE never launches a data op. me_ctrl seen while me_done=1 belongs to the retiring instruction.
//  FETCH: a new fetch address every cycle (throughput 1/cycle). At the edge leaving FETCH:
//   if_rdata<=ram_rdata and if_valid=1 for the following cycle. Latency is 2 edges from if_addr sample
//   to if_valid. if_valid=0 in all other cycles; if_rdata holds its value.
//  DREAD: ram_addr<=me_addr, ce_n=0, oe_n=0 for READ_CYCLES cycles.
//   At the last edge: me_rdata<=ram_rdata, then go to DONE.
//  Write sequence: DW_SETUP 1 cycle (addr, wdata, ce_n=0, oe_n=1, we_n=1).
//   DW_PULSE WRITE_CYCLES cycles (we_n=0). DW_HOLD 1 cycle (we_n=1, addr/data unchanged). Then DONE.
//   oe_n is never low while we_n is low.
//  DONE: 1 cycle; me_done=1; SRAM deselected (ce_n=oe_n=we_n=1); next state chosen by launch rule.
//  me_ctrl==2'b11: treated as a write; me_rdata unchanged.
//  Address/data are captured at launch. Later changes to me_addr/me_wdata are ignored until DONE.
//  Stall length: read READ_CYCLES+1 cycles; write WRITE_CYCLES+3 cycles.
// CONFIGURATION
//  MEM_ARB_PERF_EN defined: adds outputs perf_stall_cycles[15:0] and perf_fetches[15:0].
//   Both are saturating counters at 16'hFFFF, cleared by rst.
//   They count cycles with stall=1 and if_valid pulses respectively.
//  MEM_ARB_PERF_EN undefined: those ports and counters do not exist; behaviour otherwise identical.
// STRUCTURE
//  Package mem_arb_pkg: state enum; MEM_RD_BIT=1, MEM_WR_BIT=0; strobe reset constants.
//  Sub-module mem_arb_cycle_timer: loadable down-counter, reused for READ_CYCLES and WRITE_CYCLES.
//   It raises expire on the final cycle of the timed state.
// TESTING (READ_CYCLES=1, WRITE_CYCLES=2; SRAM model: comb read, writes on we_n rising edge)
//  1. rst=1 mid-run -> ce_n/oe_n/we_n=1, if_valid=0, stall=0, me_done=0 immediately, without a clock edge.
//  2. Fetch only: if_addr=0x0000,0x0001,0x0002 on consecutive cycles; model returns addr^0xA5A5.
//     -> if_valid on 3 consecutive cycles; if_rdata=0xA5A5,0xA5A4,0xA5A7.
//  3. Load: me_ctrl=2'b10, me_addr=0x8010, mem[0x8010]=0x1234 -> stall=1 for 2 cycles.
//     me_done on 3rd cycle; me_rdata=0x1234; fetch resumes the next cycle.
//  4. Store then load: me_ctrl=2'b01, me_addr=0x0042, me_wdata=0xBEEF -> we_n=0 exactly 2 cycles, stall=1 for 5 cycles.
//     A following read of 0x0042 returns 0xBEEF. Check oe_n/we_n are never both low.
//  5. me_ctrl=2'b11, me_addr=0x0010, me_wdata=0x5555, prior me_rdata=0x1234 -> mem[0x0010]=0x5555.
//     me_rdata stays 0x1234. me_ctrl held through DONE gives no second access.
//  6. rst asserted during DW_PULSE -> we_n=1 same cycle, state IDLE.
//     After release, fetches restart from if_addr. With MEM_ARB_PERF_EN, perf counters read 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the SRAM port arbiter (mem_port_arbiter).
package mem_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DREAD,
        ST_DW_SETUP,
        ST_DW_PULSE,
        ST_DW_HOLD,
        ST_DONE
    } state_t;

    localparam int MEM_RD_BIT = 1;
    localparam int MEM_WR_BIT = 0;

    localparam logic CE_N_RST = 1'b1;
    localparam logic OE_N_RST = 1'b1;
    localparam logic WE_N_RST = 1'b1;

    localparam int TIMER_W = 8;

endpackage

// File: rtl/mem_arb_cycle_timer.sv
// Loadable down-counter; expire is high on the final cycle of a timed state.
module mem_arb_cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] cycles,
    output logic         expire
);

    logic [W-1:0] cnt;

    // Loading cycles-1 makes a count of 1 expire in the very first timed cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= cycles - W'(1);
        else if (cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port SRAM arbiter: data port has priority over instruction fetch.
// Optional MEM_ARB_PERF_EN adds saturating stall/fetch performance counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int READ_CYCLES  = 1,
    parameter int WRITE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic [ADDR_W-1:0] me_addr,
    input  logic [1:0]        me_ctrl,
    input  logic [DATA_W-1:0] me_wdata,
    output logic [DATA_W-1:0] me_rdata,
    output logic              me_done,
    output logic              stall,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [15:0]       perf_stall_cycles,
    output logic [15:0]       perf_fetches
`endif
);

    state_t state;

    logic data_req, is_write, launch_ok, launch_rd;
    logic t_load, t_expire;
    logic [TIMER_W-1:0] t_cycles;

    assign is_write  = me_ctrl[MEM_WR_BIT];
    assign launch_ok = (state == ST_IDLE) || (state == ST_FETCH) || (state == ST_DONE);
    // A request seen in DONE belongs to the instruction that is retiring.
    assign data_req  = (me_ctrl[MEM_RD_BIT] | me_ctrl[MEM_WR_BIT]) && (state != ST_DONE);
    assign launch_rd = launch_ok && data_req && !is_write;

    assign t_load   = launch_rd || (state == ST_DW_SETUP);
    assign t_cycles = (state == ST_DW_SETUP) ? TIMER_W'(WRITE_CYCLES) : TIMER_W'(READ_CYCLES);

    assign stall = (me_ctrl != 2'b00) && !me_done && !rst;

    mem_arb_cycle_timer #(.W(TIMER_W)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (t_load),
        .cycles (t_cycles),
        .expire (t_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            ram_ce_n  <= CE_N_RST;
            ram_oe_n  <= OE_N_RST;
            ram_we_n  <= WE_N_RST;
            ram_addr  <= '0;
            ram_wdata <= '0;
            if_rdata  <= '0;
            if_valid  <= 1'b0;
            me_rdata  <= '0;
            me_done   <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            me_done  <= 1'b0;
            if (state == ST_FETCH) begin
                if_rdata <= ram_rdata;
                if_valid <= 1'b1;
            end
            case (state)
                ST_IDLE, ST_FETCH, ST_DONE: begin
                    ram_ce_n <= 1'b0;
                    ram_we_n <= 1'b1;
                    if (data_req) begin
                        ram_addr <= me_addr;
                        if (is_write) begin
                            ram_wdata <= me_wdata;
                            ram_oe_n  <= 1'b1;
                            state     <= ST_DW_SETUP;
                        end else begin
                            ram_oe_n <= 1'b0;
                            state    <= ST_DREAD;
                        end
                    end else begin
                        ram_addr <= if_addr;
                        ram_oe_n <= 1'b0;
                        state    <= ST_FETCH;
                    end
                end
                ST_DREAD: begin
                    if (t_expire) begin
                        me_rdata <= ram_rdata;
                        me_done  <= 1'b1;
                        ram_ce_n <= 1'b1;
                        ram_oe_n <= 1'b1;
                        state    <= ST_DONE;
                    end
                end
                ST_DW_SETUP: begin
                    ram_we_n <= 1'b0;
                    state    <= ST_DW_PULSE;
                end
                ST_DW_PULSE: begin
                    if (t_expire) begin
                        ram_we_n <= 1'b1;
                        state    <= ST_DW_HOLD;
                    end
                end
                ST_DW_HOLD: begin
                    me_done  <= 1'b1;
                    ram_ce_n <= 1'b1;
                    ram_oe_n <= 1'b1;
                    ram_we_n <= 1'b1;
                    state    <= ST_DONE;
                end
                default: begin
                    ram_ce_n <= CE_N_RST;
                    ram_oe_n <= OE_N_RST;
                    ram_we_n <= WE_N_RST;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cycles <= '0;
            perf_fetches      <= '0;
        end else begin
            if (stall && perf_stall_cycles != 16'hFFFF)
                perf_stall_cycles <= perf_stall_cycles + 16'd1;
            if (if_valid && perf_fetches != 16'hFFFF)
                perf_fetches <= perf_fetches + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a behavioural async SRAM model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] if_addr = '0;
    logic [15:0] if_rdata;
    logic        if_valid;
    logic [15:0] me_addr = '0;
    logic [1:0]  me_ctrl = '0;
    logic [15:0] me_wdata = '0;
    logic [15:0] me_rdata;
    logic        me_done;
    logic        stall;
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic        ram_ce_n, ram_oe_n, ram_we_n;
`ifdef MEM_ARB_PERF_EN
    logic [15:0] perf_stall_cycles, perf_fetches;
`endif

    int errors = 0;
    int checks = 0;

    logic [15:0] fq[$];
    logic [15:0] lq[$];

    // SRAM model: unwritten words read as addr^0xA5A5; writes land on we_n rising edge.
    logic [15:0] mem [logic [15:0]];
    logic        bd_we = 1'b0;
    logic [15:0] bd_addr = '0, bd_data = '0;
    int          mem_gen = 0;
    int          wr_count = 0;

    always #5 clk = ~clk;

    always @(posedge ram_we_n or posedge bd_we) begin
        if (bd_we)
            mem[bd_addr] = bd_data;
        else if (!rst && !ram_ce_n) begin
            mem[ram_addr] = ram_wdata;
            wr_count++;
        end
        mem_gen++;
    end

    always @(ram_addr or mem_gen)
        ram_rdata = mem.exists(ram_addr) ? mem[ram_addr] : (ram_addr ^ 16'hA5A5);

    mem_port_arbiter #(
        .ADDR_W(16), .DATA_W(16), .READ_CYCLES(1), .WRITE_CYCLES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .me_addr   (me_addr),
        .me_ctrl   (me_ctrl),
        .me_wdata  (me_wdata),
        .me_rdata  (me_rdata),
        .me_done   (me_done),
        .stall     (stall),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .ram_ce_n  (ram_ce_n),
        .ram_oe_n  (ram_oe_n),
        .ram_we_n  (ram_we_n)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_fetches      (perf_fetches)
`endif
    );

    task automatic backdoor_write(input logic [15:0] a, input logic [15:0] d);
        bd_addr = a;
        bd_data = d;
        bd_we   = 1'b1;
        #1 bd_we = 1'b0;
    endtask

    // Drives one data request and measures it until me_done (bounded). No comparisons here.
    task automatic run_op(input logic [1:0] ctrl, input logic [15:0] addr, input logic [15:0] wdata,
                          output int stalls, output int we_lows, output int overlap,
                          output bit done, output logic [15:0] rd);
        me_ctrl = ctrl; me_addr = addr; me_wdata = wdata;
        stalls = 0; we_lows = 0; overlap = 0; done = 1'b0; rd = '0;
        #1;
        for (int c = 0; c < 32 && !done; c++) begin
            if (me_done) begin
                done = 1'b1;
                rd   = me_rdata;
            end else begin
                stalls  += int'(stall);
                we_lows += int'(!ram_we_n);
                overlap += int'(!ram_we_n && !ram_oe_n);
                @(negedge clk); #1;
                if (c == 0) begin
                    me_addr  = 16'hFFFF;
                    me_wdata = 16'h0000;
                end
            end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++; if (ram_ce_n !== 1'b1) begin errors++; $display("FAIL rst_ce_n got=%b exp=1", ram_ce_n); end
        checks++; if (ram_oe_n !== 1'b1) begin errors++; $display("FAIL rst_oe_n got=%b exp=1", ram_oe_n); end
        checks++; if (ram_we_n !== 1'b1) begin errors++; $display("FAIL rst_we_n got=%b exp=1", ram_we_n); end
        checks++; if (ram_addr !== 16'h0) begin errors++; $display("FAIL rst_ram_addr got=%h exp=0000", ram_addr); end
        checks++; if (if_valid !== 1'b0 || me_done !== 1'b0 || stall !== 1'b0) begin errors++;
            $display("FAIL rst_flags got=%b%b%b exp=000", if_valid, me_done, stall); end
        checks++; if (if_rdata !== 16'h0 || me_rdata !== 16'h0) begin errors++;
            $display("FAIL rst_rdata got=%h/%h exp=0000/0000", if_rdata, me_rdata); end
`ifdef MEM_ARB_PERF_EN
        checks++; if (perf_stall_cycles !== 16'h0 || perf_fetches !== 16'h0) begin errors++;
            $display("FAIL rst_perf got=%h/%h exp=0/0", perf_stall_cycles, perf_fetches); end
`endif
        if_addr = 16'h0100;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (ram_ce_n !== 1'b0 || ram_oe_n !== 1'b0 || ram_addr !== 16'h0100) begin errors++;
            $display("FAIL first_fetch got=%b%b %h exp=00 0100", ram_ce_n, ram_oe_n, ram_addr); end
        @(negedge clk);
        checks++; if (if_valid !== 1'b1 || if_rdata !== 16'hA4A5) begin errors++;
            $display("FAIL first_fetch_data got=%b %h exp=1 a4a5", if_valid, if_rdata); end
        // Asynchronous assertion mid-cycle: outputs must drop without a clock edge.
        #2 rst = 1'b1;
        #1;
        checks++; if (ram_ce_n !== 1'b1 || ram_oe_n !== 1'b1 || ram_we_n !== 1'b1) begin errors++;
            $display("FAIL async_rst_strobes got=%b%b%b exp=111", ram_ce_n, ram_oe_n, ram_we_n); end
        checks++; if (if_valid !== 1'b0 || stall !== 1'b0 || me_done !== 1'b0) begin errors++;
            $display("FAIL async_rst_flags got=%b%b%b exp=000", if_valid, stall, me_done); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fetch;
        logic [15:0] exp;
        for (int i = 0; i < 5; i++) begin
            if (i >= 2) begin
                exp = fq.pop_front();
                checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL fetch_valid_%0d got=%b exp=1", i, if_valid); end
                checks++; if (if_rdata !== exp) begin errors++; $display("FAIL fetch_data_%0d got=%h exp=%h", i, if_rdata, exp); end
            end
            if (i < 3) begin
                if_addr = 16'(i);
                fq.push_back(16'(i) ^ 16'hA5A5);
            end
            @(negedge clk);
        end
        checks++; if (fq.size() != 0) begin errors++; $display("FAIL fetch_queue got=%0d exp=0", fq.size()); end
    endtask

    task automatic test_load;
        int s, w, o; bit d; logic [15:0] rd, exp;
        backdoor_write(16'h8010, 16'h1234);
        @(negedge clk);
        lq.push_back(16'h1234);
        run_op(2'b10, 16'h8010, 16'h0, s, w, o, d, rd);
        checks++; if (d !== 1'b1) begin errors++; $display("FAIL load_done got=%b exp=1", d); end
        exp = lq.pop_front();
        checks++; if (rd !== exp) begin errors++; $display("FAIL load_rdata got=%h exp=%h", rd, exp); end
        checks++; if (s != 2) begin errors++; $display("FAIL load_stalls got=%0d exp=2", s); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL load_stall_at_done got=%b exp=0", stall); end
        if_addr = 16'h0005;
        me_ctrl = 2'b00;
        @(negedge clk);
        checks++; if (me_done !== 1'b0) begin errors++; $display("FAIL load_done_pulse got=%b exp=0", me_done); end
        checks++; if (ram_ce_n !== 1'b0 || ram_oe_n !== 1'b0 || ram_addr !== 16'h0005) begin errors++;
            $display("FAIL load_fetch_resume got=%b%b %h exp=00 0005", ram_ce_n, ram_oe_n, ram_addr); end
        @(negedge clk);
        checks++; if (if_valid !== 1'b1 || if_rdata !== 16'hA5A0) begin errors++;
            $display("FAIL load_fetch_data got=%b %h exp=1 a5a0", if_valid, if_rdata); end
    endtask

    task automatic test_store_load;
        int s, w, o; bit d; logic [15:0] rd, exp;
        run_op(2'b01, 16'h0042, 16'hBEEF, s, w, o, d, rd);
        checks++; if (d !== 1'b1) begin errors++; $display("FAIL store_done got=%b exp=1", d); end
        checks++; if (s != 5) begin errors++; $display("FAIL store_stalls got=%0d exp=5", s); end
        checks++; if (w != 2) begin errors++; $display("FAIL store_we_cycles got=%0d exp=2", w); end
        checks++; if (o != 0) begin errors++; $display("FAIL store_oe_we_overlap got=%0d exp=0", o); end
        checks++; if (mem[16'h0042] !== 16'hBEEF) begin errors++; $display("FAIL store_mem got=%h exp=beef", mem[16'h0042]); end
        me_ctrl = 2'b00;
        @(negedge clk);
        lq.push_back(16'hBEEF);
        run_op(2'b10, 16'h0042, 16'h0, s, w, o, d, rd);
        exp = lq.pop_front();
        checks++; if (d !== 1'b1 || rd !== exp) begin errors++; $display("FAIL store_readback got=%b %h exp=1 %h", d, rd, exp); end
        checks++; if (o != 0) begin errors++; $display("FAIL readback_overlap got=%0d exp=0", o); end
        me_ctrl = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_both_bits;
        int s, w, o, wc0; bit d; logic [15:0] rd, exp;
        lq.push_back(16'h1234);
        run_op(2'b10, 16'h8010, 16'h0, s, w, o, d, rd);
        exp = lq.pop_front();
        checks++; if (d !== 1'b1 || rd !== exp) begin errors++; $display("FAIL rmw_preload got=%b %h exp=1 %h", d, rd, exp); end
        me_ctrl = 2'b00;
        @(negedge clk);
        wc0 = wr_count;
        run_op(2'b11, 16'h0010, 16'h5555, s, w, o, d, rd);
        checks++; if (d !== 1'b1 || s != 5 || w != 2) begin errors++;
            $display("FAIL rmw_as_write got=%b s%0d w%0d exp=1 s5 w2", d, s, w); end
        checks++; if (rd !== 16'h1234) begin errors++; $display("FAIL rmw_rdata_kept got=%h exp=1234", rd); end
        checks++; if (mem[16'h0010] !== 16'h5555) begin errors++; $display("FAIL rmw_mem got=%h exp=5555", mem[16'h0010]); end
        // me_ctrl stays 2'b11 across DONE: the next cycle must be a plain fetch.
        @(negedge clk);
        checks++; if (ram_we_n !== 1'b1 || ram_oe_n !== 1'b0 || me_done !== 1'b0) begin errors++;
            $display("FAIL rmw_no_relaunch got=%b%b%b exp=100", ram_we_n, ram_oe_n, me_done); end
        me_ctrl = 2'b00;
        repeat (2) @(negedge clk);
        checks++; if (wr_count != wc0 + 1) begin errors++; $display("FAIL rmw_write_count got=%0d exp=%0d", wr_count, wc0 + 1); end
    endtask

    task automatic test_reset_mid_write;
        me_ctrl = 2'b01; me_addr = 16'h0077; me_wdata = 16'h1111;
        repeat (2) @(negedge clk);
        checks++; if (ram_we_n !== 1'b0) begin errors++; $display("FAIL midw_pulse got=%b exp=0", ram_we_n); end
        #1 rst = 1'b1;
        #1;
        checks++; if (ram_we_n !== 1'b1 || ram_ce_n !== 1'b1 || ram_oe_n !== 1'b1) begin errors++;
            $display("FAIL midw_rst_strobes got=%b%b%b exp=111", ram_we_n, ram_ce_n, ram_oe_n); end
        checks++; if (stall !== 1'b0 || me_done !== 1'b0 || if_valid !== 1'b0) begin errors++;
            $display("FAIL midw_rst_flags got=%b%b%b exp=000", stall, me_done, if_valid); end
`ifdef MEM_ARB_PERF_EN
        checks++; if (perf_stall_cycles !== 16'h0 || perf_fetches !== 16'h0) begin errors++;
            $display("FAIL midw_perf got=%h/%h exp=0/0", perf_stall_cycles, perf_fetches); end
`endif
        me_ctrl = 2'b00;
        if_addr = 16'h0200;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (ram_ce_n !== 1'b0 || ram_oe_n !== 1'b0 || ram_we_n !== 1'b1 || ram_addr !== 16'h0200) begin errors++;
            $display("FAIL midw_restart got=%b%b%b %h exp=001 0200", ram_ce_n, ram_oe_n, ram_we_n, ram_addr); end
        @(negedge clk);
        checks++; if (if_valid !== 1'b1 || if_rdata !== 16'hA7A5) begin errors++;
            $display("FAIL midw_restart_data got=%b %h exp=1 a7a5", if_valid, if_rdata); end
    endtask

    initial begin
        test_reset;
        test_fetch;
        test_load;
        test_store_load;
        test_both_bits;
        test_reset_mid_write;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
